// File: rtl/sobel_pkg.sv
// Shared widths, gradient type and Sobel kernel coefficients for the
// 3x3 edge-detection operators.
package sobel_pkg;

    localparam int PIX_W   = 8;
    localparam int GRAD_W  = 11;
    localparam int MAG_MAX = 255;

    typedef logic signed [GRAD_W-1:0] grad_t;

    localparam grad_t K_SIDE   = 11'sd1;
    localparam grad_t K_CENTER = 11'sd2;

    // Zero-extend an unsigned pixel into the signed gradient domain.
    function automatic grad_t pix_ext(input logic [PIX_W-1:0] p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    function automatic grad_t kernel_sum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
        return pix_ext(a) * K_SIDE + pix_ext(b) * K_CENTER + pix_ext(c) * K_SIDE;
    endfunction

endpackage

// File: rtl/sobel_gradient.sv
// Registered Sobel Gx/Gy over a 3x3 neighbourhood with valid passthrough.
// Pixel pRC is row R (0 = top), column C (2 = newest).
module sobel_gradient
    import sobel_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [PIX_W-1:0]         p00,
    input  logic [PIX_W-1:0]         p01,
    input  logic [PIX_W-1:0]         p02,
    input  logic [PIX_W-1:0]         p10,
    input  logic [PIX_W-1:0]         p11,
    input  logic [PIX_W-1:0]         p12,
    input  logic [PIX_W-1:0]         p20,
    input  logic [PIX_W-1:0]         p21,
    input  logic [PIX_W-1:0]         p22,
    output logic                     valid_o,
    output logic signed [GRAD_W-1:0] gx_o,
    output logic signed [GRAD_W-1:0] gy_o
);

    grad_t gx_next;
    grad_t gy_next;

    // The centre pixel carries zero weight in both kernels.
    logic  unused_center;
    assign unused_center = ^p11;

    assign gx_next = kernel_sum(p02, p12, p22) - kernel_sum(p00, p10, p20);
    assign gy_next = kernel_sum(p20, p21, p22) - kernel_sum(p00, p01, p02);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            gx_o    <= '0;
            gy_o    <= '0;
        end else begin
            valid_o <= valid_i;
            gx_o    <= gx_next;
            gy_o    <= gy_next;
        end
    end

endmodule

// File: rtl/sobel_window_3x3.sv
// Sliding 3x3 window over incoming pixel columns, Sobel gradient, and a
// saturated magnitude with edge flag and end-of-line marker.
module sobel_window_3x3
    import sobel_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int THRESHOLD = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [PIX_W-1:0] data0_i,
    input  logic [PIX_W-1:0] data1_i,
    input  logic [PIX_W-1:0] data2_i,
    output logic             valid_o,
    output logic [PIX_W-1:0] mag_o,
    output logic             edge_o,
    output logic             eol_o
);

    localparam int                COL_W         = $clog2(WIDTH);
    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(WIDTH - 1);
    localparam logic [COL_W-1:0]  COL_FIRST_WIN = COL_W'(2);
    localparam logic [GRAD_W-1:0] MAG_LIMIT     = GRAD_W'(MAG_MAX);
    localparam logic [PIX_W:0]    THRESH        = (PIX_W + 1)'(THRESHOLD);

    logic [PIX_W-1:0]  win [3][3];
    logic [COL_W-1:0]  col;
    logic              win_valid;
    logic              win_eol;

    logic              grad_valid;
    logic              grad_eol;
    grad_t             gx;
    grad_t             gy;

    logic [GRAD_W-1:0] abs_gx;
    logic [GRAD_W-1:0] abs_gy;
    logic [GRAD_W-1:0] mag_sum;
    logic [PIX_W-1:0]  mag_sat;

    // Row 0 is the oldest line (data2_i); column 2 always holds the newest pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            col       <= '0;
            win_valid <= 1'b0;
            win_eol   <= 1'b0;
        end else begin
            win_valid <= valid_i && (col >= COL_FIRST_WIN);
            win_eol   <= valid_i && (col == COL_LAST);
            if (valid_i) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= data2_i;
                win[1][2] <= data1_i;
                win[2][2] <= data0_i;
                col       <= (col == COL_LAST) ? '0 : col + 1'b1;
            end
        end
    end

    sobel_gradient u_gradient (
        .clk     (clk),
        .rst     (rst),
        .valid_i (win_valid),
        .p00     (win[0][0]),
        .p01     (win[0][1]),
        .p02     (win[0][2]),
        .p10     (win[1][0]),
        .p11     (win[1][1]),
        .p12     (win[1][2]),
        .p20     (win[2][0]),
        .p21     (win[2][1]),
        .p22     (win[2][2]),
        .valid_o (grad_valid),
        .gx_o    (gx),
        .gy_o    (gy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grad_eol <= 1'b0;
        end else begin
            grad_eol <= win_eol;
        end
    end

    assign abs_gx  = gx[GRAD_W-1] ? GRAD_W'(-gx) : GRAD_W'(gx);
    assign abs_gy  = gy[GRAD_W-1] ? GRAD_W'(-gy) : GRAD_W'(gy);
    assign mag_sum = abs_gx + abs_gy;
    assign mag_sat = (mag_sum > MAG_LIMIT) ? PIX_W'(MAG_MAX) : mag_sum[PIX_W-1:0];

    // Result registers only load on a valid window so they hold between beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            mag_o   <= '0;
            edge_o  <= 1'b0;
            eol_o   <= 1'b0;
        end else begin
            valid_o <= grad_valid;
            if (grad_valid) begin
                mag_o  <= mag_sat;
                edge_o <= ({1'b0, mag_sat} >= THRESH);
                eol_o  <= grad_eol;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Directed self-checking bench for sobel_window_3x3 with WIDTH=8, THRESHOLD=100.
module tb_sobel_window_3x3;

    logic       clk;
    logic       rst;
    logic       valid_i;
    logic [7:0] data0_i;
    logic [7:0] data1_i;
    logic [7:0] data2_i;
    logic       valid_o;
    logic [7:0] mag_o;
    logic       edge_o;
    logic       eol_o;

    int errors = 0;
    int checks = 0;

    sobel_window_3x3 #(.WIDTH(8), .THRESHOLD(100)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .data0_i (data0_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .valid_o (valid_o),
        .mag_o   (mag_o),
        .edge_o  (edge_o),
        .eol_o   (eol_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2);
        @(negedge clk);
        valid_i = v;
        data0_i = d0;
        data1_i = d1;
        data2_i = d2;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        valid_i = 1'b0;
        data0_i = '0;
        data1_i = '0;
        data2_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        valid_i = 1'b1;
        data0_i = 8'd200;
        data1_i = 8'd10;
        data2_i = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b0 || mag_o !== 8'd0 || edge_o !== 1'b0 || eol_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got v=%b m=%0d e=%b l=%b exp v=0 m=0 e=0 l=0",
                     valid_o, mag_o, edge_o, eol_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst     = 1'b1;
    endtask

    task automatic test_flat();
        int  c;
        logic ev;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i < 16) step(1'b1, 8'd100, 8'd100, 8'd100);
            else        step(1'b0, 8'd0, 8'd0, 8'd0);
            if (i >= 2) begin
                c  = (i - 2) % 8;
                ev = (c >= 2);
                checks++;
                if (valid_o !== ev) begin
                    errors++;
                    $display("[TB] FAIL flat_valid col=%0d got=%b exp=%b", c, valid_o, ev);
                end
                if (ev) begin
                    checks++;
                    if (mag_o !== 8'd0 || edge_o !== 1'b0 || eol_o !== (c == 7)) begin
                        errors++;
                        $display("[TB] FAIL flat_out col=%0d got m=%0d e=%b l=%b exp m=0 e=0 l=%b",
                                 c, mag_o, edge_o, eol_o, (c == 7));
                    end
                end
            end
        end
    endtask

    task automatic test_vstep();
        logic [7:0] exp_mag [8];
        logic [7:0] pix;
        int         c;
        logic       ev;
        exp_mag = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pix = (i < 4) ? 8'd0 : 8'd255;
            if (i < 8) step(1'b1, pix, pix, pix);
            else       step(1'b0, 8'd0, 8'd0, 8'd0);
            if (i >= 2) begin
                c  = i - 2;
                ev = (c >= 2);
                checks++;
                if (valid_o !== ev) begin
                    errors++;
                    $display("[TB] FAIL vstep_valid col=%0d got=%b exp=%b", c, valid_o, ev);
                end
                if (ev) begin
                    checks++;
                    if (mag_o !== exp_mag[c] || edge_o !== (exp_mag[c] == 8'd255)
                        || eol_o !== (c == 7)) begin
                        errors++;
                        $display("[TB] FAIL vstep_out col=%0d got m=%0d e=%b l=%b exp m=%0d e=%b l=%b",
                                 c, mag_o, edge_o, eol_o, exp_mag[c],
                                 (exp_mag[c] == 8'd255), (c == 7));
                    end
                end
            end
        end
    endtask

    task automatic test_ramp();
        logic [7:0] pix;
        int         c;
        logic       ev;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pix = 8'(10 * i);
            if (i < 8) step(1'b1, pix, pix, pix);
            else       step(1'b0, 8'd0, 8'd0, 8'd0);
            if (i >= 2) begin
                c  = i - 2;
                ev = (c >= 2);
                checks++;
                if (valid_o !== ev) begin
                    errors++;
                    $display("[TB] FAIL ramp_valid col=%0d got=%b exp=%b", c, valid_o, ev);
                end
                if (ev) begin
                    checks++;
                    if (mag_o !== 8'd80 || edge_o !== 1'b0 || eol_o !== (c == 7)) begin
                        errors++;
                        $display("[TB] FAIL ramp_out col=%0d got m=%0d e=%b l=%b exp m=80 e=0 l=%b",
                                 c, mag_o, edge_o, eol_o, (c == 7));
                    end
                end
            end
        end
    endtask

    task automatic test_vgrad();
        int   c;
        logic ev;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1'b1, 8'd30, 8'd0, 8'd0);
            else       step(1'b0, 8'd0, 8'd0, 8'd0);
            if (i >= 2) begin
                c  = i - 2;
                ev = (c >= 2);
                checks++;
                if (valid_o !== ev) begin
                    errors++;
                    $display("[TB] FAIL vgrad_valid col=%0d got=%b exp=%b", c, valid_o, ev);
                end
                if (ev) begin
                    checks++;
                    if (mag_o !== 8'd120 || edge_o !== 1'b1 || eol_o !== (c == 7)) begin
                        errors++;
                        $display("[TB] FAIL vgrad_out col=%0d got m=%0d e=%b l=%b exp m=120 e=1 l=%b",
                                 c, mag_o, edge_o, eol_o, (c == 7));
                    end
                end
            end
        end
    endtask

    // Ramp with two idle cycles after every accepted column; idle data is junk.
    task automatic test_gaps();
        logic [7:0] held;
        int         j;
        int         c;
        logic       ev;
        do_reset();
        held = 8'd0;
        for (int i = 0; i < 26; i++) begin
            if (i < 24 && (i % 3) == 0) step(1'b1, 8'(10 * (i / 3)), 8'(10 * (i / 3)), 8'(10 * (i / 3)));
            else                        step(1'b0, 8'hAA, 8'h55, 8'hFF);
            if (i >= 2) begin
                j  = i - 2;
                c  = j / 3;
                ev = ((j % 3) == 0) && (c >= 2);
                checks++;
                if (valid_o !== ev) begin
                    errors++;
                    $display("[TB] FAIL gaps_valid cyc=%0d got=%b exp=%b", j, valid_o, ev);
                end
                checks++;
                if (ev) begin
                    if (mag_o !== 8'd80 || edge_o !== 1'b0 || eol_o !== (c == 7)) begin
                        errors++;
                        $display("[TB] FAIL gaps_out col=%0d got m=%0d e=%b l=%b exp m=80 e=0 l=%b",
                                 c, mag_o, edge_o, eol_o, (c == 7));
                    end
                    held = 8'd80;
                end else if (mag_o !== held) begin
                    errors++;
                    $display("[TB] FAIL gaps_hold cyc=%0d got m=%0d exp m=%0d", j, mag_o, held);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int   c;
        logic ev;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(10 * i), 8'(10 * i), 8'(10 * i));
        checks++;
        if (valid_o !== 1'b1 || mag_o !== 8'd80) begin
            errors++;
            $display("[TB] FAIL rstmid_pre got v=%b m=%0d exp v=1 m=80", valid_o, mag_o);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || mag_o !== 8'd0 || eol_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_async got v=%b m=%0d l=%b exp v=0 m=0 l=0",
                     valid_o, mag_o, eol_o);
        end
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1'b1, 8'(10 * i), 8'(10 * i), 8'(10 * i));
            else       step(1'b0, 8'd0, 8'd0, 8'd0);
            c  = i - 2;
            ev = (c >= 2);
            checks++;
            if (valid_o !== ev) begin
                errors++;
                $display("[TB] FAIL rstmid_valid col=%0d got=%b exp=%b", c, valid_o, ev);
            end
            if (ev) begin
                checks++;
                if (mag_o !== 8'd80 || edge_o !== 1'b0 || eol_o !== (c == 7)) begin
                    errors++;
                    $display("[TB] FAIL rstmid_out col=%0d got m=%0d e=%b l=%b exp m=80 e=0 l=%b",
                             c, mag_o, edge_o, eol_o, (c == 7));
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        valid_i = 1'b0;
        data0_i = '0;
        data1_i = '0;
        data2_i = '0;
        $display("[TB] starting sobel_window_3x3 bench");
        test_reset();
        test_flat();
        test_vstep();
        test_ramp();
        test_vgrad();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
